// File: rtl/cmd_reply_encoder.sv
// cmd_reply_encoder: builds a fixed 60-byte Ethernet reply frame from a captured
// command reply and streams it one byte per AXI-Stream beat.
module cmd_reply_encoder #(
  parameter logic [47:0] HOST_MAC_ADDR = 48'h985aebdb066f,
  parameter logic [47:0] FPGA_MAC_ADDR = 48'h5a0102030405
) (
  input  logic        gtx_tclk_i,
  input  logic        gtx_tresetn_i,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [15:0] rsp_type_i,
  input  logic [15:0] rsp_op_i,
  input  logic [7:0]  rsp_id_i,
  input  logic [31:0] rsp_addr_i,
  input  logic [31:0] rsp_data_i,
  output logic [7:0]  tx_axis_tdata_o,
  output logic        tx_axis_tvalid_o,
  output logic        tx_axis_tlast_o,
  input  logic        tx_axis_tready_i,
  output logic        busy_o,
  output logic [15:0] frame_count_o
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic armed;
  logic [15:0] type_q, op_q;
  logic [7:0] id_q;
  logic [31:0] addr_q, data_q;
  logic [239:0] hdr, sh;
  logic accept, hs;
  assign accept = rsp_valid_i && rsp_ready_o;
  assign hs = tx_axis_tvalid_o && tx_axis_tready_i;
  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i)
    if (gtx_tresetn_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? HDR : IDLE;
      HDR:     state_nx = (hs && cnt == 6'd13) ? PAYLOAD : HDR;
      PAYLOAD: state_nx = (hs && cnt == 6'd29) ? PAD : PAYLOAD;
      PAD:     state_nx = (hs && cnt == 6'd59) ? IDLE : PAD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i)
    if (gtx_tresetn_i) begin
      cnt <= '0;
      armed <= 1'b0;
      frame_count_o <= '0;
      type_q <= '0;
      op_q <= '0;
      id_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        cnt <= '0;
        type_q <= rsp_type_i;
        op_q <= rsp_op_i;
        id_q <= rsp_id_i;
        addr_q <= rsp_addr_i;
        data_q <= rsp_data_i;
      end else if (hs) cnt <= (cnt == 6'd59) ? 6'd0 : cnt + 6'd1;
      if (hs && tx_axis_tlast_o) frame_count_o <= frame_count_o + 16'd1;
    end
  // First 30 bytes in wire order; shifting by the byte index past 29 yields the zero pad.
  assign hdr = {HOST_MAC_ADDR, FPGA_MAC_ADDR, 16'h0010, type_q, op_q, id_q, 24'h0,
                addr_q[7:0], addr_q[15:8], addr_q[23:16], addr_q[31:24],
                data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
  assign sh = hdr << {cnt, 3'b000};
  assign busy_o = state != IDLE;
  assign tx_axis_tvalid_o = busy_o;
  assign tx_axis_tdata_o = busy_o ? sh[239:232] : 8'h00;
  assign tx_axis_tlast_o = state == PAD && cnt == 6'd59;
  assign rsp_ready_o = armed && state == IDLE;
endmodule

// File: tb/tb_cmd_reply_encoder.sv
// tb_cmd_reply_encoder: table-driven frames checked byte-by-byte against a scoreboard
// queue, plus hand-written back-to-back and mid-frame reset sequences.
module tb_cmd_reply_encoder;
  logic clk = 1'b0, rst = 1'b1;
  logic rsp_valid, rsp_ready, tvalid, tlast, tready, busy;
  logic [15:0] rsp_type, rsp_op, frame_count;
  logic [7:0] rsp_id, tdata;
  logic [31:0] rsp_addr, rsp_data;
  always #5 clk = ~clk;

  cmd_reply_encoder dut (
    .gtx_tclk_i(clk), .gtx_tresetn_i(rst),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready),
    .rsp_type_i(rsp_type), .rsp_op_i(rsp_op), .rsp_id_i(rsp_id),
    .rsp_addr_i(rsp_addr), .rsp_data_i(rsp_data),
    .tx_axis_tdata_o(tdata), .tx_axis_tvalid_o(tvalid), .tx_axis_tlast_o(tlast),
    .tx_axis_tready_i(tready), .busy_o(busy), .frame_count_o(frame_count)
  );

  typedef struct {
    logic [15:0] t, op;
    logic [7:0] id;
    logic [31:0] addr, data;
    int mode, cycles;
    logic [7:0] b16, b17, b18, b22, b26;
  } vec_t;

  vec_t tbl[4];
  logic [7:0] exp_q[$];
  logic [7:0] got[60];
  int total = 0, bad = 0, exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] fb(input vec_t v, input int i);
    logic [47:0] host = 48'h985aebdb066f, fpga = 48'h5a0102030405;
    if (i < 6) return host[8*(5-i) +: 8];
    if (i < 12) return fpga[8*(11-i) +: 8];
    case (i)
      13: return 8'h10;
      14: return v.t[15:8];
      15: return v.t[7:0];
      16: return v.op[15:8];
      17: return v.op[7:0];
      18: return v.id;
      default: ;
    endcase
    if (i >= 22 && i < 26) return v.addr[8*(i-22) +: 8];
    if (i >= 26 && i < 30) return v.data[8*(i-26) +: 8];
    return 8'h00;
  endfunction

  task automatic drive_req(input vec_t v);
    rsp_type = v.t; rsp_op = v.op; rsp_id = v.id; rsp_addr = v.addr; rsp_data = v.data;
    rsp_valid = 1'b1;
    for (int i = 0; i < 60; i++) exp_q.push_back(fb(v, i));
  endtask

  task automatic wait_accept(input bit hold, output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      rsp_valid = 1'b0;
      rsp_type = 16'($urandom); rsp_op = 16'($urandom); rsp_id = 8'($urandom);
      rsp_addr = $urandom; rsp_data = $urandom;
    end
  endtask

  // mode 0: tready=1, 1: toggling, 2: 32-cycle stall at byte 20, 3: stop at byte 30
  task automatic stream(input int mode, input bit chain, input vec_t nv, output int cyc);
    int beat = 0, stall = 0, stall_bad = 0;
    bit done = 0, stall_now;
    logic [7:0] e;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("latency_tvalid", tvalid, 1);
      if (mode == 3 && beat == 30) done = 1;
      else begin
        stall_now = mode == 2 && beat == 20 && stall < 32;
        tready = mode == 1 ? (cyc % 2 == 0) : !stall_now;
        if (stall_now) begin
          stall++;
          if (!(tvalid === 1'b1 && tdata === 8'h00 && tlast === 1'b0)) stall_bad++;
          if (stall == 32) chk("stall_hold_bad_cycles", stall_bad, 0);
        end
        if (tvalid && tready) begin
          e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
          chk($sformatf("byte%0d", beat), tdata, e);
          chk($sformatf("tlast%0d", beat), tlast, beat == 59);
          got[beat] = tdata;
          beat++;
          if (tlast) begin
            done = 1;
            if (chain) drive_req(nv);
          end
        end
      end
    end
    if (!done) chk("stream_timeout", 0, 1);
    tready = 1'b1;
  endtask

  initial begin
    vec_t va, v1, v2;
    int n, cyc;
    tbl[0] = '{16'h4343, 16'h5252, 8'h04, 32'h0, 32'hfeedbeef, 0, 60, 8'h52, 8'h52, 8'h04, 8'h00, 8'hef};
    tbl[1] = '{16'h4343, 16'h5252, 8'h04, 32'h0, 32'hfeedbeef, 1, 120, 8'h52, 8'h52, 8'h04, 8'h00, 8'hef};
    tbl[2] = '{16'h4343, 16'h5252, 8'h09, 32'hcafe0102, 32'h01020304, 2, 92, 8'h52, 8'h52, 8'h09, 8'h02, 8'h04};
    tbl[3] = '{16'h4646, 16'h5757, 8'h07, 32'h10, 32'h12345678, 0, 60, 8'h57, 8'h57, 8'h07, 8'h10, 8'h78};
    va = tbl[3]; va.id = 8'h33;
    v1 = tbl[0]; v1.id = 8'h01;
    v2 = tbl[0]; v2.id = 8'h02;
    rsp_valid = 0; tready = 1; rsp_type = 0; rsp_op = 0; rsp_id = 0; rsp_addr = 0; rsp_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_tdata", tdata, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_ready", rsp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", frame_count, 0);
    rst = 0;
    #1 chk("ready_before_edge", rsp_ready, 0);
    @(posedge clk); #1 chk("ready_after_reset", rsp_ready, 1);
    // reset in the middle of a frame
    drive_req(va);
    wait_accept(0, n);
    stream(3, 0, va, cyc);
    chk("abort_busy_before", busy, 1);
    rst = 1;
    #1;
    chk("abort_tvalid", tvalid, 0);
    chk("abort_tlast", tlast, 0);
    chk("abort_count", frame_count, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      drive_req(tbl[i]);
      wait_accept(0, n);
      stream(tbl[i].mode, 0, tbl[i], cyc);
      chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cycles);
      chk($sformatf("v%0d_b0", i), got[0], 8'h98);
      chk($sformatf("v%0d_b11", i), got[11], 8'h05);
      chk($sformatf("v%0d_b16", i), got[16], tbl[i].b16);
      chk($sformatf("v%0d_b17", i), got[17], tbl[i].b17);
      chk($sformatf("v%0d_b18", i), got[18], tbl[i].b18);
      chk($sformatf("v%0d_b22", i), got[22], tbl[i].b22);
      chk($sformatf("v%0d_b26", i), got[26], tbl[i].b26);
      @(posedge clk); #1;
      exp_cnt++;
      chk($sformatf("v%0d_count", i), frame_count, exp_cnt);
      chk($sformatf("v%0d_tvalid_after", i), tvalid, 0);
      chk($sformatf("v%0d_ready_after", i), rsp_ready, 1);
      chk($sformatf("v%0d_queue_empty", i), exp_q.size(), 0);
    end
    // request held high across a frame: accepted one cycle after tlast
    drive_req(v1);
    wait_accept(1, n);
    stream(0, 1, v2, cyc);
    chk("b2b_ready_at_tlast", rsp_ready, 0);
    wait_accept(0, n);
    chk("b2b_gap", n, 0);
    exp_cnt++;
    chk("b2b_count1", frame_count, exp_cnt);
    stream(0, 0, v2, cyc);
    chk("b2b_b18", got[18], 8'h02);
    @(posedge clk); #1;
    exp_cnt++;
    chk("b2b_count2", frame_count, exp_cnt);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
